// File: rtl/dbg_uart_bridge_if.sv
// dbg_uart_bridge_if: debug port between the UART bridge (master) and the core debug unit (slave).
interface dbg_uart_bridge_if;
    logic [7:0]  dbg_cmd_o;
    logic [31:0] dbg_addr_o;
    logic [31:0] dbg_data_o;
    logic [31:0] dbg_data_i;
    logic        dbg_ready_i;
    modport master (output dbg_cmd_o, dbg_addr_o, dbg_data_o, input dbg_data_i, dbg_ready_i);
    modport slave  (input dbg_cmd_o, dbg_addr_o, dbg_data_o, output dbg_data_i, dbg_ready_i);
endinterface

// File: rtl/dbg_uart_bridge.sv
// dbg_uart_bridge: 9-byte UART command frames to debug-port transactions, 4-byte read data returned over UART.
module dbg_uart_bridge #(
    parameter int CLK_FREQ      = 50000000,
    parameter int BAUD          = 115200,
    parameter int FRAME_TIMEOUT = 100000
) (
    input  logic               sys_clk_i,
    input  logic               rstn_i,
    input  logic               uart_rx_i,
    output logic               uart_tx_o,
    output logic               busy_o,
    output logic               err_o,
    dbg_uart_bridge_if.master  dbg
);
    localparam int CPB = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(CPB);
    localparam int TW  = $clog2(FRAME_TIMEOUT + 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
    typedef enum logic [2:0] {RX_CMD, RX_ADDR, RX_DATA, ISSUE, RESP} st_t;

    rx_st_t          rx_st;
    st_t             st;
    logic            rx_s1, rx_s2, rx_prev, rx_valid, rx_err;
    logic [CW-1:0]   rx_cnt, tx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_byte, cmd, tx_cur;
    logic [31:0]     addr, data, resp;
    logic [1:0]      byte_cnt, tx_idx;
    logic [3:0]      tx_bit;
    logic [TW-1:0]   idle_cnt;
    logic            tx_val;

    // Synchronizers reset low so a new start bit needs the line to be seen idle-high first
    always_ff @(posedge sys_clk_i or negedge rstn_i)
        if (!rstn_i) begin
            rx_st    <= R_IDLE;
            rx_s1    <= 1'b0;
            rx_s2    <= 1'b0;
            rx_prev  <= 1'b0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_byte  <= '0;
        end else begin
            rx_s1    <= uart_rx_i;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            rx_cnt   <= rx_cnt + CW'(1);
            case (rx_st)
                R_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_prev && !rx_s2) rx_st <= R_START;
                end
                R_START: if (rx_cnt == CW'(CPB / 2 - 1)) begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                    rx_st  <= rx_s2 ? R_IDLE : R_DATA;
                end
                R_DATA: if (rx_cnt == CW'(CPB - 1)) begin
                    rx_cnt  <= '0;
                    rx_byte <= {rx_s2, rx_byte[7:1]};
                    rx_bit  <= rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_st <= R_STOP;
                end
                default: if (rx_cnt == CW'(CPB - 1)) begin
                    rx_st    <= R_IDLE;
                    rx_valid <= rx_s2;
                    rx_err   <= !rx_s2;
                end
            endcase
        end

    always_comb begin
        tx_cur = resp[{tx_idx, 3'b000} +: 8];
        tx_val = (tx_bit == 4'd0) ? 1'b0 : (tx_bit == 4'd9) ? 1'b1 : tx_cur[3'(tx_bit - 4'd1)];
    end

    always_ff @(posedge sys_clk_i or negedge rstn_i)
        if (!rstn_i) begin
            st             <= RX_CMD;
            cmd            <= '0;
            addr           <= '0;
            data           <= '0;
            resp           <= '0;
            byte_cnt       <= '0;
            idle_cnt       <= '0;
            tx_cnt         <= '0;
            tx_bit         <= '0;
            tx_idx         <= '0;
            uart_tx_o      <= 1'b1;
            busy_o         <= 1'b0;
            err_o          <= 1'b0;
            dbg.dbg_cmd_o  <= '0;
            dbg.dbg_addr_o <= '0;
            dbg.dbg_data_o <= '0;
        end else begin
            err_o     <= rx_err || (rx_valid && (st == ISSUE || st == RESP));
            uart_tx_o <= 1'b1;
            case (st)
                RX_CMD: if (rx_valid) begin
                    cmd      <= rx_byte;
                    busy_o   <= 1'b1;
                    byte_cnt <= '0;
                    idle_cnt <= '0;
                    st       <= RX_ADDR;
                end
                RX_ADDR, RX_DATA: if (rx_err || idle_cnt == TW'(FRAME_TIMEOUT - 1)) begin
                    err_o  <= 1'b1;
                    busy_o <= 1'b0;
                    st     <= RX_CMD;
                end else if (rx_valid) begin
                    idle_cnt <= '0;
                    byte_cnt <= byte_cnt + 2'd1;
                    if (st == RX_ADDR) begin
                        addr <= {rx_byte, addr[31:8]};
                        if (byte_cnt == 2'd3) st <= RX_DATA;
                    end else begin
                        data <= {rx_byte, data[31:8]};
                        if (byte_cnt == 2'd3 && cmd == 8'h00) begin
                            busy_o <= 1'b0;
                            st     <= RX_CMD;
                        end else if (byte_cnt == 2'd3) begin
                            dbg.dbg_cmd_o  <= cmd;
                            dbg.dbg_addr_o <= addr;
                            dbg.dbg_data_o <= {rx_byte, data[31:8]};
                            st             <= ISSUE;
                        end
                    end
                end else idle_cnt <= idle_cnt + TW'(1);
                ISSUE: if (dbg.dbg_ready_i) begin
                    resp          <= dbg.dbg_data_i;
                    dbg.dbg_cmd_o <= 8'h00;
                    tx_cnt        <= '0;
                    tx_bit        <= '0;
                    tx_idx        <= '0;
                    st            <= RESP;
                end
                RESP: begin
                    uart_tx_o <= tx_val;
                    if (tx_cnt == CW'(CPB - 1)) begin
                        tx_cnt <= '0;
                        tx_bit <= (tx_bit == 4'd9) ? 4'd0 : tx_bit + 4'd1;
                        if (tx_bit == 4'd9) tx_idx <= tx_idx + 2'd1;
                        if (tx_bit == 4'd9 && tx_idx == 2'd3) begin
                            busy_o <= 1'b0;
                            st     <= RX_CMD;
                        end
                    end else tx_cnt <= tx_cnt + CW'(1);
                end
                default: st <= RX_CMD;
            endcase
        end
endmodule

// File: tb/tb_dbg_uart_bridge.sv
// tb_dbg_uart_bridge: randomized frames against a byte-level UART/debug-port reference model.
`timescale 1ns/1ps
module tb_dbg_uart_bridge;
    localparam int CPB = 10;

    logic clk = 1'b0, rstn = 1'b0, rx = 1'b1;
    logic tx, busy, err;
    int tests = 0, fails = 0, err_cnt = 0, cmd_nz = 0;
    logic [7:0] tx_q[$];

    dbg_uart_bridge_if dbg();

    dbg_uart_bridge #(.CLK_FREQ(1000000), .BAUD(100000), .FRAME_TIMEOUT(500)) dut (
        .sys_clk_i(clk), .rstn_i(rstn), .uart_rx_i(rx), .uart_tx_o(tx),
        .busy_o(busy), .err_o(err), .dbg(dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err) err_cnt <= err_cnt + 1;
        if (dbg.dbg_cmd_o != 8'h00) cmd_nz <= cmd_nz + 1;
    end

    // Host-side receiver: samples bit centres, keeps only bytes with a good stop bit
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rstn && tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                if (tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clk);
                        b[i] = tx;
                    end
                    repeat (CPB) @(negedge clk);
                    if (tx === 1'b1) tx_q.push_back(b);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic run_txn(input logic [7:0] c, input logic [31:0] a, d, r, input int dly, input bit ovr);
        logic [7:0] fr[9];
        int n, e0;
        e0 = err_cnt;
        tx_q.delete();
        fr[0] = c;
        for (int i = 0; i < 4; i++) begin
            fr[1 + i] = 8'(a >> (8 * i));
            fr[5 + i] = 8'(d >> (8 * i));
        end
        for (int i = 0; i < 9; i++) send_byte(fr[i], 1'b1);
        n = 0;
        while (dbg.dbg_cmd_o == 8'h00 && n < 50) begin @(negedge clk); n++; end
        tests++; if (dbg.dbg_cmd_o !== c) begin fails++; $display("FAIL issue_cmd got %h exp %h", dbg.dbg_cmd_o, c); end
        tests++; if (dbg.dbg_addr_o !== a) begin fails++; $display("FAIL issue_addr got %h exp %h", dbg.dbg_addr_o, a); end
        tests++; if (dbg.dbg_data_o !== d) begin fails++; $display("FAIL issue_data got %h exp %h", dbg.dbg_data_o, d); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL issue_busy got %b exp 1", busy); end
        repeat (dly) @(negedge clk);
        if (ovr) begin
            send_byte(8'h55, 1'b1);
            repeat (5) @(negedge clk);
            tests++; if (err_cnt !== e0 + 1) begin fails++; $display("FAIL overrun_err got %0d exp %0d", err_cnt - e0, 1); end
            e0 = err_cnt;
        end
        tests++; if (dbg.dbg_cmd_o !== c) begin fails++; $display("FAIL held_cmd got %h exp %h", dbg.dbg_cmd_o, c); end
        dbg.dbg_ready_i = 1'b1;
        dbg.dbg_data_i  = r;
        @(negedge clk);
        dbg.dbg_ready_i = 1'b0;
        dbg.dbg_data_i  = $urandom;
        tests++; if (dbg.dbg_cmd_o !== 8'h00) begin fails++; $display("FAIL post_ready_cmd got %h exp 00", dbg.dbg_cmd_o); end
        tests++; if (dbg.dbg_addr_o !== a) begin fails++; $display("FAIL post_ready_addr got %h exp %h", dbg.dbg_addr_o, a); end
        n = 0;
        while (tx_q.size() < 4 && n < 1000) begin @(negedge clk); n++; end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL busy_at_last_byte got %b exp 1", busy); end
        tests++;
        if (tx_q.size() != 4) begin
            fails++; $display("FAIL resp_count got %0d exp 4", tx_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++; if (tx_q[i] !== 8'(r >> (8 * i))) begin fails++; $display("FAIL resp_byte%0d got %h exp %h", i, tx_q[i], 8'(r >> (8 * i))); end
            end
        end
        n = 0;
        while (busy && n < 30) begin @(negedge clk); n++; end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_end got %b exp 0", busy); end
        tests++; if (err_cnt !== e0) begin fails++; $display("FAIL spurious_err got %0d exp 0", err_cnt - e0); end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL rst_tx got %b exp 1", tx); end
        tests++; if (dbg.dbg_cmd_o !== 8'h00) begin fails++; $display("FAIL rst_cmd got %h exp 00", dbg.dbg_cmd_o); end
        tests++; if (dbg.dbg_addr_o !== 32'h0) begin fails++; $display("FAIL rst_addr got %h exp 0", dbg.dbg_addr_o); end
        tests++; if (dbg.dbg_data_o !== 32'h0) begin fails++; $display("FAIL rst_data got %h exp 0", dbg.dbg_data_o); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b exp 0", busy); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err got %b exp 0", err); end
        rstn = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_read;
        run_txn(8'h02, 32'h80000010, 32'h0, 32'hDEADBEEF, 5, 1'b0);
    endtask

    task automatic test_write;
        run_txn(8'h01, 32'h00000004, 32'h12345678, $urandom, 3, 1'b0);
    endtask

    task automatic test_nop;
        int e0, c0;
        e0 = err_cnt;
        c0 = cmd_nz;
        tx_q.delete();
        send_byte(8'h00, 1'b1);
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL nop_busy got %b exp 1", busy); end
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b1);
        repeat (20) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL nop_busy_end got %b exp 0", busy); end
        repeat (200) @(negedge clk);
        tests++; if (tx_q.size() != 0) begin fails++; $display("FAIL nop_tx got %0d bytes exp 0", tx_q.size()); end
        tests++; if (cmd_nz !== c0) begin fails++; $display("FAIL nop_cmd got %0d active cycles exp 0", cmd_nz - c0); end
        tests++; if (err_cnt !== e0) begin fails++; $display("FAIL nop_err got %0d exp 0", err_cnt - e0); end
    endtask

    task automatic test_timeout;
        int e0, n;
        e0 = err_cnt;
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
        n = 0;
        while (err_cnt == e0 && n < 700) begin @(negedge clk); n++; end
        tests++; if (n < 490 || n > 510) begin fails++; $display("FAIL timeout_latency got %0d exp ~500", n); end
        repeat (100) @(negedge clk);
        tests++; if (err_cnt !== e0 + 1) begin fails++; $display("FAIL timeout_err got %0d exp 1", err_cnt - e0); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL timeout_busy got %b exp 0", busy); end
        run_txn(8'h02, $urandom, $urandom, $urandom, 2, 1'b0);
    endtask

    task automatic test_framing;
        int e0;
        e0 = err_cnt;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        tests++; if (err_cnt !== e0) begin fails++; $display("FAIL glitch_err got %0d exp 0", err_cnt - e0); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy got %b exp 0", busy); end
        send_byte(8'h02, 1'b1);
        send_byte(8'h33, 1'b0);
        repeat (20) @(negedge clk);
        tests++; if (err_cnt !== e0 + 1) begin fails++; $display("FAIL framing_err got %0d exp 1", err_cnt - e0); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL framing_busy got %b exp 0", busy); end
        run_txn(8'h02, $urandom, $urandom, $urandom, 1, 1'b0);
    endtask

    task automatic test_overrun;
        run_txn(8'($urandom_range(1, 255)), $urandom, $urandom, $urandom, 4, 1'b1);
    endtask

    task automatic test_reset_mid;
        logic [7:0] fr[9];
        logic [31:0] r;
        int n;
        fr[0] = 8'h02;
        for (int i = 1; i < 9; i++) fr[i] = 8'($urandom);
        for (int i = 0; i < 9; i++) send_byte(fr[i], 1'b1);
        n = 0;
        while (dbg.dbg_cmd_o == 8'h00 && n < 50) begin @(negedge clk); n++; end
        rstn = 1'b0;
        #1;
        tests++; if (dbg.dbg_cmd_o !== 8'h00) begin fails++; $display("FAIL rst_issue_cmd got %h exp 00", dbg.dbg_cmd_o); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_issue_busy got %b exp 0", busy); end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        tx_q.delete();
        for (int i = 0; i < 9; i++) send_byte(fr[i], 1'b1);
        n = 0;
        while (dbg.dbg_cmd_o == 8'h00 && n < 50) begin @(negedge clk); n++; end
        r = {8'($urandom), 8'($urandom), 8'h00, 8'($urandom)};
        dbg.dbg_ready_i = 1'b1;
        dbg.dbg_data_i  = r;
        @(negedge clk);
        dbg.dbg_ready_i = 1'b0;
        n = 0;
        while (tx_q.size() < 1 && n < 300) begin @(negedge clk); n++; end
        repeat (35) @(negedge clk);
        tests++; if (tx !== 1'b0) begin fails++; $display("FAIL resp_byte1_bit got %b exp 0", tx); end
        rstn = 1'b0;
        #1;
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL rst_resp_tx got %b exp 1", tx); end
        tests++; if (dbg.dbg_cmd_o !== 8'h00) begin fails++; $display("FAIL rst_resp_cmd got %h exp 00", dbg.dbg_cmd_o); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_resp_busy got %b exp 0", busy); end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (150) @(negedge clk);
        run_txn(8'h02, $urandom, $urandom, $urandom, 5, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 4; k++)
            run_txn(8'($urandom_range(1, 255)), $urandom, $urandom, $urandom, $urandom_range(0, 8), 1'b0);
    endtask

    initial begin
        dbg.dbg_ready_i = 1'b0;
        dbg.dbg_data_i  = '0;
        test_reset();
        test_read();
        test_write();
        test_nop();
        test_timeout();
        test_framing();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired before all scenarios completed");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end
endmodule

// File: doc/dbg_uart_bridge.md
Name: dbg_uart_bridge

Overview:
- Host-facing debug bridge that converts UART command frames into transactions on the core debug port (dbg_cmd/addr/data/ready) and returns the result over UART.
- Sits directly upstream of core_wrapper's debug interface.
- Lets the FPGA top and the simulation bench drive the core's debug unit from a serial link instead of directly driven pins.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be >= 4).
- FRAME_TIMEOUT, 100000, idle clock cycles inside a partial frame before the parser aborts.

Ports:
- sys_clk_i  in  1  system clock; all logic on rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- uart_rx_i  in  1  serial input from host, 8N1, idle high, asynchronous to sys_clk_i.
- uart_tx_o  out  1  serial output to host, 8N1, idle high.
- dbg_cmd_o  out  8  debug command to core; 0x00 = NOP.
- dbg_addr_o  out  32  debug address.
- dbg_data_o  out  32  debug write data.
- dbg_data_i  in  32  debug read data from core, valid while dbg_ready_i = 1.
- dbg_ready_i  in  1  core completion strobe for the current command.
- busy_o  out  1  high from first frame byte until the response is fully sent.
- err_o  out  1  one-cycle pulse on any framing, overrun or timeout error.

Behaviour:
- Reset values (asynchronous, rstn_i low): uart_tx_o=1, dbg_cmd_o=0x00, dbg_addr_o=0, dbg_data_o=0, busy_o=0, err_o=0, FSM=RX_CMD, all counters 0.
- RX:
  - 2-flop synchronizer on uart_rx_i.
  - A falling edge while the receiver is idle starts a byte.
  - Start bit is re-checked at CLKS_PER_BIT/2; if it is high, the byte is ignored (glitch, no err).
  - Data bits are sampled at bit centres, LSB first.
  - If the stop bit samples 0, the byte is discarded, err_o pulses and the parser returns to RX_CMD.
  - rx_valid is a 1-cycle strobe per good byte.
- Frame (host to bridge), 9 bytes:
  - CMD, ADDR[7:0], ADDR[15:8], ADDR[23:16], ADDR[31:24], DATA[7:0] .. DATA[31:24].
  - Little-endian within each word.
- FSM:
  - RX_CMD: on rx_valid, latch cmd and set busy_o=1, then go to RX_ADDR.
  - RX_ADDR: take 4 bytes (2-bit byte counter), then go to RX_DATA.
  - RX_DATA: take 4 bytes.
    - If cmd = 0x00: clear busy_o, return to RX_CMD, no port activity, no response.
    - Otherwise go to ISSUE.
  - ISSUE:
    - dbg_cmd_o/addr/data are driven from the latched frame starting the first cycle in ISSUE and held stable.
    - The bridge waits indefinitely for dbg_ready_i (no timeout).
    - On the first cycle with dbg_ready_i=1: capture dbg_data_i into resp, drive dbg_cmd_o=0x00 the next cycle, go to RESP.
    - dbg_addr_o/dbg_data_o keep their last values.
  - RESP: transmit resp as 4 bytes, LSB byte first, back-to-back (next start bit immediately after previous stop bit). After the last stop bit: busy_o=0, go to RX_CMD.
- Timeout:
  - In RX_ADDR/RX_DATA, an idle counter resets on each rx_valid.
  - When it reaches FRAME_TIMEOUT: partial frame dropped, err_o pulses, busy_o=0, go to RX_CMD.
  - The counter is inactive in RX_CMD, ISSUE and RESP.
- Overrun: a good byte received while in ISSUE or RESP is dropped and err_o pulses; the current transaction continues unaffected.
- TX bit timing: each bit lasts exactly CLKS_PER_BIT cycles; uart_tx_o is registered (glitch-free).
- Reset mid-operation: an in-flight frame, command or response is abandoned. After release, the bridge only accepts a new frame after seeing rx idle-high followed by a falling edge.

Test Plan (CLK_FREQ=1000000, BAUD=100000, CLKS_PER_BIT=10, FRAME_TIMEOUT=500; uart_tx_o looped to a bench UART monitor):
- Read frame 02 10 00 00 80 00 00 00 00; core model asserts dbg_ready_i 5 cycles after ISSUE with dbg_data_i=0xDEADBEEF:
  - dbg_cmd_o=0x02, dbg_addr_o=0x80000010 held until ready; dbg_cmd_o=0x00 one cycle after ready.
  - UART returns EF BE AD DE; busy_o falls after the last stop bit.
- Write frame 01 04 00 00 00 78 56 34 12:
  - dbg_addr_o=0x00000004, dbg_data_o=0x12345678, dbg_cmd_o=0x01 until dbg_ready_i.
  - Response contains dbg_data_i at the ready cycle.
- NOP frame 00 followed by 8 arbitrary bytes: dbg_cmd_o stays 0x00, no UART output, busy_o high during the frame and then 0.
- Timeout and framing errors:
  - Send 3 bytes of a frame, then idle 600 cycles: err_o pulses once near cycle 500 after the last byte, busy_o=0.
  - A subsequent full read frame completes normally.
  - A byte sent with stop bit 0 gives an err_o pulse and parser reset.
- Overrun: during ISSUE with dbg_ready_i held low, send byte 0x55: err_o pulses, dbg_cmd_o unchanged. On ready, the normal 4-byte response follows.
- Reset mid-response: assert rstn_i low during the 2nd response byte: uart_tx_o=1 and dbg_cmd_o=0x00 immediately. After release, a new read frame succeeds.
